// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : memory-access stage of a 64-bit in-order pipeline.
//
// Issues one data-bus request per load/store instruction, stalls the
// upstream stages until the response arrives, and registers the result
// into the mem register that feeds writeback. It also drives a forwarding
// bypass from that register.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous, active-high
//   ex_valid, ex   execute-stage instruction and result (held stable while stall=1)
//   dreq_*         data-bus request: valid, byte address, size, byte strobes,
//                  lane-aligned store data (strobe==0 means read)
//   dresp_data_ok  response strobe that completes the outstanding request
//   dresp_data     raw 64-bit response word
//   stall          freezes all upstream stages
//   mem_valid, mem registered result handed to writeback
//   fwd            bypass taken from the mem register
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } decoded_op_t;

    typedef struct packed {
        decoded_op_t op;
        logic        reg_write;
        logic        mem_access;
        logic        mem_to_reg;
        logic        mem_write;
    } control_t;

    typedef struct packed {
        logic [31:0] instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] rd;
        logic [63:0] aluout;
        logic [63:0] csr_data;
        logic [11:0] csr_waddr;
    } exec_data_t;

    typedef struct packed {
        logic [31:0] instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] writedata;
        logic [63:0] mem_addr;
        logic [63:0] csr_data;
        logic [11:0] csr_waddr;
    } mem_data_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        logic [63:0] data;
    } fwd_data_t;

    typedef enum logic [1:0] {IDLE, WAITING, OVER} mem_access_state_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  exec_data_t  ex,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        stall,
    output logic        mem_valid,
    output mem_data_t   mem,
    output fwd_data_t   fwd
);

    mem_access_state_t state_q;
    logic [63:0]       load_buf_q;
    logic [63:0]       load_data_d;
    mem_data_t         mem_q;
    mem_data_t         mem_d;
    logic              mem_valid_q;
    logic              mem_load_d;
    logic              mem_req;
    logic [2:0]        offset;
    logic [63:0]       resp_shifted;

    assign mem_req = ex_valid & ex.ctl.mem_access;
    assign offset  = ex.aluout[2:0];

    // Request handshake outputs. They are combinational so that the request
    // goes out in the same IDLE cycle the instruction is presented; the
    // address/data fields stay stable because upstream is stalled.
    always_comb begin
        dreq_valid = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    dreq_valid = mem_req;
                    stall      = mem_req;
                end
                WAITING: begin
                    dreq_valid = 1'b1;
                    stall      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dreq_addr = ex.aluout;
    assign dreq_data = ex.rd << {offset, 3'b000};

    always_comb begin
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        case (ex.ctl.op)
            OP_LB, OP_LBU: dreq_size = 3'd0;
            OP_LH, OP_LHU: dreq_size = 3'd1;
            OP_LW, OP_LWU: dreq_size = 3'd2;
            OP_SB: begin
                dreq_size   = 3'd0;
                dreq_strobe = 8'h01 << offset;
            end
            OP_SH: begin
                dreq_size   = 3'd1;
                dreq_strobe = 8'h03 << offset;
            end
            OP_SW: begin
                dreq_size   = 3'd2;
                dreq_strobe = 8'h0F << offset;
            end
            OP_SD: begin
                dreq_size   = 3'd3;
                dreq_strobe = 8'hFF;
            end
            default: ;
        endcase
    end

    // Load alignment: bring the addressed byte lane down to bit 0, then
    // truncate and extend according to the access type.
    assign resp_shifted = dresp_data >> {offset, 3'b000};

    always_comb begin
        load_data_d = resp_shifted;
        case (ex.ctl.op)
            OP_LB:   load_data_d = {{56{resp_shifted[7]}},  resp_shifted[7:0]};
            OP_LH:   load_data_d = {{48{resp_shifted[15]}}, resp_shifted[15:0]};
            OP_LW:   load_data_d = {{32{resp_shifted[31]}}, resp_shifted[31:0]};
            OP_LBU:  load_data_d = {56'd0, resp_shifted[7:0]};
            OP_LHU:  load_data_d = {48'd0, resp_shifted[15:0]};
            OP_LWU:  load_data_d = {32'd0, resp_shifted[31:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            load_buf_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req)
                        state_q <= WAITING;
                end
                WAITING: begin
                    if (dresp_data_ok) begin
                        load_buf_q <= load_data_d;
                        state_q    <= OVER;
                    end
                end
                OVER:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The mem register takes a new result for a plain instruction in IDLE,
    // or for a memory instruction in OVER (ex is still held at that point,
    // and stall drops so upstream advances on the same edge).
    assign mem_load_d = (state_q == IDLE && ex_valid && !ex.ctl.mem_access) ||
                        (state_q == OVER);

    always_comb begin
        mem_d.instr     = ex.instr;
        mem_d.ctl       = ex.ctl;
        mem_d.dst       = ex.dst;
        mem_d.writedata = ex.ctl.mem_to_reg ? load_buf_q : ex.aluout;
        mem_d.mem_addr  = ex.aluout;
        mem_d.csr_data  = ex.csr_data;
        mem_d.csr_waddr = ex.csr_waddr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_q       <= '0;
        end else begin
            mem_valid_q <= mem_load_d;
            if (mem_load_d)
                mem_q <= mem_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem       = mem_q;

    assign fwd.valid = mem_valid_q & mem_q.ctl.reg_write & (mem_q.dst != 5'd0);
    assign fwd.dst   = mem_q.dst;
    assign fwd.data  = mem_q.writedata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a
// randomized instruction stream compared against an arithmetic reference.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    exec_data_t  ex;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall;
    logic        mem_valid;
    mem_data_t   mem;
    fwd_data_t   fwd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex            (ex),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .stall         (stall),
        .mem_valid     (mem_valid),
        .mem           (mem),
        .fwd           (fwd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_load(input decoded_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic bit is_store(input decoded_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic int op_bytes(input decoded_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_LWU, OP_SW: return 4;
            default:              return 8;
        endcase
    endfunction

    function automatic logic [7:0] ref_strobe(input decoded_op_t op, input logic [63:0] addr);
        int m;
        if (!is_store(op)) return 8'h00;
        if (op == OP_SD) return 8'hFF;
        m = ((1 << op_bytes(op)) - 1) << int'(addr[2:0]);
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_load(input decoded_op_t op, input logic [63:0] addr,
                                             input logic [63:0] rdata);
        logic [63:0] v, mask;
        int bits;
        v    = rdata >> (8 * int'(addr[2:0]));
        bits = 8 * op_bytes(op);
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v    = v & mask;
            if (op inside {OP_LB, OP_LH, OP_LW} && v[bits-1])
                v = v | ~mask;
        end
        return v;
    endfunction

    function automatic exec_data_t make_ex(input decoded_op_t op, input logic [63:0] addr,
                                           input logic [63:0] rd, input logic [4:0] dst);
        exec_data_t e;
        e.instr          = $urandom;
        e.ctl.op         = op;
        e.ctl.mem_access = (op != OP_ADD);
        e.ctl.mem_to_reg = is_load(op);
        e.ctl.mem_write  = is_store(op);
        e.ctl.reg_write  = !is_store(op);
        e.dst            = dst;
        e.rd             = rd;
        e.aluout         = addr;
        e.csr_data       = {$urandom, $urandom};
        e.csr_waddr      = 12'($urandom);
        return e;
    endfunction

    // Present one instruction (called 1 time unit after a rising edge) and
    // follow it until its mem_valid pulse; the next call may start at once.
    task automatic run_instr(input decoded_op_t op, input logic [63:0] addr,
                             input logic [63:0] rd, input logic [63:0] rdata,
                             input int nwait, input logic [4:0] dst);
        exec_data_t e;
        logic [63:0] expw;
        int stall_cycles;
        e = make_ex(op, addr, rd, dst);
        ex = e;
        ex_valid = 1'b1;
        dresp_data_ok = 1'b0;
        stall_cycles = 0;
        #1;
        if (op == OP_ADD) begin
            chk("alu_stall", stall, 0);
            chk("alu_dreq_valid", dreq_valid, 0);
            @(posedge clk); #1;
            expw = addr;
        end else begin
            chk("req_valid", dreq_valid, 1);
            chk("req_addr", dreq_addr, addr);
            chk("req_size", dreq_size, 64'($clog2(op_bytes(op))));
            chk("req_strobe", dreq_strobe, ref_strobe(op, addr));
            if (is_store(op))
                chk("req_data", dreq_data, rd << (8 * int'(addr[2:0])));
            if (stall) stall_cycles++;
            @(posedge clk); #1;
            for (int w = 1; w <= nwait; w++) begin
                chk("wait_dreq_valid", dreq_valid, 1);
                chk("wait_mem_valid", mem_valid, 0);
                if (stall) stall_cycles++;
                dresp_data    = (w == nwait) ? rdata : {$urandom, $urandom};
                dresp_data_ok = (w == nwait);
                @(posedge clk); #1;
            end
            dresp_data_ok = 1'b0;
            dresp_data    = {$urandom, $urandom};
            chk("stall_cycles", stall_cycles, nwait + 1);
            chk("over_stall", stall, 0);
            chk("over_dreq_valid", dreq_valid, 0);
            chk("over_mem_valid", mem_valid, 0);
            @(posedge clk); #1;
            expw = is_load(op) ? ref_load(op, addr, rdata) : addr;
        end
        chk("mem_valid", mem_valid, 1);
        chk("writedata", mem.writedata, expw);
        chk("mem_addr", mem.mem_addr, addr);
        chk("mem_dst", mem.dst, dst);
        chk("mem_instr", mem.instr, e.instr);
        chk("fwd_valid", fwd.valid, (!is_store(op) && dst != 0));
        chk("fwd_data", fwd.data, expw);
        $display("txn op=%s addr=%h wait=%0d writedata=%h", op.name(), addr, nwait, mem.writedata);
    endtask

    // One cycle with no instruction; an unsolicited data_ok must be ignored.
    task automatic idle_cycle(input bit stray_ok);
        ex_valid      = 1'b0;
        dresp_data_ok = stray_ok;
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_dreq_valid", dreq_valid, 0);
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        chk("idle_mem_valid", mem_valid, 0);
        #1;
        chk("idle_after_stall", stall, 0);
    endtask

    initial begin
        decoded_op_t op;
        reset         = 1'b1;
        ex            = make_ex(OP_LD, 64'h40, 64'h1, 5'd1);
        ex_valid      = 1'b1;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dreq_valid", dreq_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_fwd_valid", fwd.valid, 0);
        chk("rst_mem_wd", mem.writedata, 0);
        chk("rst_mem_addr", mem.mem_addr, 0);
        ex_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;

        // Non-memory pass-through.
        run_instr(OP_ADD, 64'h2A, 64'h0, 64'h0, 0, 5'd5);
        chk("fwd_dst", fwd.dst, 5);
        idle_cycle(1'b1);
        // Sign-extending byte load, data_ok in third wait cycle.
        run_instr(OP_LB, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3, 5'd7);
        idle_cycle(1'b0);
        // Zero-extending word load.
        run_instr(OP_LWU, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 5'd8);
        // Sub-word store.
        run_instr(OP_SH, 64'h3006, 64'h1234, 64'h0, 1, 5'd0);
        // Back-to-back: store then ALU op with no bubble in between.
        run_instr(OP_SD, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 5'd0);
        run_instr(OP_ADD, 64'h99, 64'h0, 64'h0, 0, 5'd9);

        // Reset in the middle of an access.
        ex       = make_ex(OP_LD, 64'h5000, 64'h0, 5'd3);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        chk("mid_wait_stall", stall, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_dreq_valid", dreq_valid, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_mem_valid", mem_valid, 0);
        ex_valid      = 1'b0;
        dresp_data_ok = 1'b1;
        @(posedge clk); #1;
        reset         = 1'b0;
        dresp_data_ok = 1'b0;
        idle_cycle(1'b0);
        chk("post_rst_fwd_valid", fwd.valid, 0);
        run_instr(OP_ADD, 64'h77, 64'h0, 64'h0, 0, 5'd2);

        // Randomized stream.
        for (int n = 0; n < 60; n++) begin
            op = decoded_op_t'($urandom_range(0, 11));
            run_instr(op, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(1, 4), 5'($urandom));
            if ($urandom_range(0, 2) == 0)
                idle_cycle($urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case the stimulus ever wedges.
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port ex_valid, input, 1 bit: ex carries a valid instruction.
REQ-004 SHALL have port ex, input, exec_data_t: execute-stage result; upstream holds it stable while stall=1.
REQ-005 SHALL have port dreq_valid, output, 1 bit: data-bus request valid.
REQ-006 SHALL have port dreq_addr, output, 64 bits: byte address, equal to ex.aluout.
REQ-007 SHALL have port dreq_size, output, 3 bits: access size; 0=byte, 1=half, 2=word, 3=double.
REQ-008 SHALL have port dreq_strobe, output, 8 bits: byte write enables; all-zero means read.
REQ-009 SHALL have port dreq_data, output, 64 bits: lane-aligned store data.
REQ-010 SHALL have port dresp_data_ok, input, 1 bit: response data valid; this completes the request.
REQ-011 SHALL have port dresp_data, input, 64 bits: raw 64-bit bus word.
REQ-012 SHALL have port stall, output, 1 bit: freezes all upstream stages.
REQ-013 SHALL have port mem_valid, output, 1 bit: the mem register holds a valid instruction.
REQ-014 SHALL have port mem, output, mem_data_t: registered result passed to writeback.
REQ-015 SHALL have port fwd, output, fwd_data_t: forwarding bypass taken from the mem register.

Function
REQ-016 SHALL implement a state machine using mem_access_state_t with three states: IDLE, WAITING and OVER.
REQ-017 SHALL behave as follows in IDLE:
- ex_valid=1 and ex.ctl.mem_access=1: dreq_valid=1, stall=1; next state WAITING.
- Otherwise: dreq_valid=0, stall=0.
REQ-018 SHALL behave as follows in WAITING:
- dreq_valid=1, stall=1.
- On dresp_data_ok=1, capture the processed load data into an internal buffer; next state OVER.
- Otherwise stay in WAITING.
REQ-019 SHALL ignore dresp_data_ok while in IDLE; data is accepted only in WAITING.
REQ-020 SHALL behave as follows in OVER: dreq_valid=0, stall=0; next state IDLE unconditionally.
REQ-021 SHALL hold dreq_addr, dreq_size, dreq_strobe and dreq_data stable while dreq_valid=1.
REQ-022 SHALL select dreq_size from ex.ctl.op:
- LB, LBU, SB -> 0.
- LH, LHU, SH -> 1.
- LW, LWU, SW -> 2.
- LD, SD -> 3.
REQ-023 SHALL derive strobe and store data from o=dreq_addr[2:0]:
- Store strobe: SB 8'h01<<o, SH 8'h03<<o, SW 8'h0F<<o, SD 8'hFF; bits shifted past bit 7 are dropped.
- Load strobe: 0.
- dreq_data = ex.rd << 8*o.
REQ-024 SHALL form load data as dresp_data >> 8*o, truncated to the access size:
- LB, LH, LW: sign-extend to 64 bits.
- LBU, LHU, LWU: zero-extend.
- LD: unchanged.
REQ-025 SHALL perform misaligned accesses without any check or trap.
REQ-026 SHALL update the mem register at each rising edge:
- IDLE with ex_valid=1 and no memory access: load it from ex; mem_valid=1.
- OVER: load it; mem_valid=1.
- All other cycles: mem_valid=0 (bubble); other fields don't-care.
REQ-027 SHALL set mem.writedata to the buffered load data for loads (ctl.mem_to_reg=1), and to ex.aluout otherwise.
REQ-028 SHALL set mem.mem_addr to ex.aluout and copy ctl, csr_data, csr_waddr, dst and instr unchanged from ex.
REQ-029 SHALL provide latency as follows:
- Non-memory instruction: mem_valid one edge after presentation.
- Memory instruction: latency is 2 edges plus the number of WAITING cycles; the minimum is 3 edges, reached when data_ok arrives in the first WAITING cycle.
REQ-030 SHALL drive fwd as: fwd.valid = mem_valid & mem.ctl.reg_write & (mem.dst!=0); fwd.dst = mem.dst; fwd.data = mem.writedata.
REQ-031 SHALL accept a new instruction in the IDLE cycle immediately following OVER, with no extra bubble.

Reset
REQ-032 SHALL, while reset=1, hold the state machine in IDLE and force dreq_valid=0, stall=0, mem_valid=0, all mem fields 0, and fwd.valid=0.
REQ-033 SHALL, on reset asserted mid-access (WAITING or OVER), abandon the access, discard the buffered data, and produce no mem_valid pulse for it.

Verification
REQ-034 Non-memory pass-through: ADD with aluout=0x2A, dst=5, ex_valid=1 -> next edge gives mem_valid=1, writedata=0x2A, fwd={5,0x2A,1}, and stall stays 0.
REQ-035 Sign-extending load: LB at addr 0x1003, dresp_data=0x0000_0000_8000_0000, data_ok in the 3rd WAITING cycle -> dreq_size=0, strobe=0, stall=1 for 4 cycles, then writedata=0xFFFF_FFFF_FFFF_FF80 and mem_valid=1 for exactly one cycle.
REQ-036 Zero-extending load: LWU at addr 0x2004 with dresp_data=0xDEADBEEF_00000000 -> writedata=0x0000_0000_DEAD_BEEF.
REQ-037 Sub-word store: SH at addr 0x3006 with rd=0x1234 -> dreq_strobe=0xC0 and dreq_data=0x1234_0000_0000_0000.
REQ-038 Back-to-back: SD followed by an ADD held upstream -> ADD enters in the IDLE cycle after OVER and yields mem_valid on consecutive edges with no gap.
REQ-039 Reset mid-access: reset asserted during WAITING -> dreq_valid=0 immediately, and after release state is IDLE with mem_valid=0.
